// File: rtl/lut_pkg.sv
// Shared types and constants for the LUT load sequencer.
// The LUT_LOAD_VERIFY_EN macro adds the read-back VERIFY state.
package lut_pkg;

   localparam int LUT_ADDR_W       = 12;
   localparam int LUT_DATA_W       = 8;
   localparam int LUT_SETUP_CYCLES = 1;
   localparam int LUT_PULSE_CYCLES = 2;
   // FETCH + SETUP + STROBE + HOLD for one byte
   localparam int LUT_BYTE_CYCLES  = 1 + LUT_SETUP_CYCLES + LUT_PULSE_CYCLES + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_RUN
`ifdef LUT_LOAD_VERIFY_EN
      , ST_VERIFY
`endif
   } lut_load_state_t;

endpackage

// File: rtl/lut_strobe_gen.sv
// Write-pulse timing for one LUT byte: SETUP_CYCLES setup, PULSE_CYCLES low
// strobe, one hold cycle; done is high during the hold cycle.
module lut_strobe_gen
   import lut_pkg::*;
#(
   parameter int SETUP_CYCLES = LUT_SETUP_CYCLES,
   parameter int PULSE_CYCLES = LUT_PULSE_CYCLES
) (
   input  logic CLK,
   input  logic N_RST,
   input  logic go,
   output logic n_we,
   output logic done
);

   localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   lut_load_state_t  phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             n_we_q, n_we_d;

   // NOTE: every signal gets a default before the case so no path infers a latch.
   always_comb begin
      phase_d = phase_q;
      cnt_d   = cnt_q;
      unique case (phase_q)
         ST_IDLE: begin
            if (go) begin
               phase_d = ST_SETUP;
               cnt_d   = '0;
            end
         end
         ST_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
               phase_d = ST_STROBE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
               phase_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: phase_d = ST_IDLE;
      endcase
      n_we_d = (phase_d != ST_STROBE);
   end

   // NOTE: the strobe comes straight from a flop so it is glitch-free, and the
   // asynchronous reset forces it high at once even mid-pulse.
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         phase_q <= ST_IDLE;
         cnt_q   <= '0;
         n_we_q  <= 1'b1;
      end else begin
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         n_we_q  <= n_we_d;
      end
   end

   assign n_we = n_we_q;
   assign done = (phase_q == ST_HOLD);

endmodule

// File: rtl/lut_load_ctrl.sv
// Loads a 2**ADDR_W x DATA_W LUT from a byte stream, then serves datapath reads.
// Define LUT_LOAD_VERIFY_EN to add a checksum read-back (VERIFY) after loading.
module lut_load_ctrl
   import lut_pkg::*;
#(
   parameter int ADDR_W       = LUT_ADDR_W,
   parameter int DATA_W       = LUT_DATA_W,
   parameter int SETUP_CYCLES = LUT_SETUP_CYCLES,
   parameter int PULSE_CYCLES = LUT_PULSE_CYCLES
) (
   input  logic              CLK,
   input  logic              N_RST,
   input  logic              START,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   input  logic [ADDR_W-1:0] RUN_ADDR,
   input  logic              RUN_RD,
   output logic [ADDR_W-1:0] LUT_ADDR,
   output logic [DATA_W-1:0] LUT_WDATA,
   output logic              LUT_N_WE,
   output logic              LUT_N_OE,
   input  logic [DATA_W-1:0] LUT_RDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR
);

   lut_load_state_t   state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              go;
   logic              wr_done;

`ifdef LUT_LOAD_VERIFY_EN
   localparam int SUM_W = DATA_W + 8;
   logic [SUM_W-1:0] wsum_q, wsum_d, rsum_q, rsum_d;
   logic             drain_q, drain_d, rd_valid_q, rd_valid_d, err_q, err_d;
`endif

   lut_strobe_gen #(
      .SETUP_CYCLES (SETUP_CYCLES),
      .PULSE_CYCLES (PULSE_CYCLES)
   ) u_strobe (
      .CLK   (CLK),
      .N_RST (N_RST),
      .go    (go),
      .n_we  (LUT_N_WE),
      .done  (wr_done)
   );

   // The strobe generator sequences SETUP/STROBE/HOLD itself; this FSM parks in
   // ST_SETUP for the whole write and acts on the HOLD-cycle done pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      go      = 1'b0;
`ifdef LUT_LOAD_VERIFY_EN
      wsum_d     = wsum_q;
      rsum_d     = rsum_q;
      drain_d    = drain_q;
      err_d      = err_q;
      rd_valid_d = (state_q == ST_VERIFY) && !drain_q;
      if (rd_valid_q) rsum_d = rsum_q + SUM_W'(LUT_RDATA);
`endif
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (START) begin
               state_d = ST_FETCH;
               cnt_d   = '0;
`ifdef LUT_LOAD_VERIFY_EN
               wsum_d  = '0;
               err_d   = 1'b0;
`endif
            end
         end
         ST_FETCH: begin
            if (IN_VALID) begin
               state_d = ST_SETUP;
               addr_d  = cnt_q;
               wdata_d = IN_DATA;
               go      = 1'b1;
`ifdef LUT_LOAD_VERIFY_EN
               wsum_d  = wsum_q + SUM_W'(IN_DATA);
`endif
            end
         end
         ST_SETUP, ST_STROBE, ST_HOLD: begin
            if (wr_done) begin
               if (&cnt_q) begin
`ifdef LUT_LOAD_VERIFY_EN
                  state_d = ST_VERIFY;
                  cnt_d   = '0;
                  drain_d = 1'b0;
                  rsum_d  = '0;
`else
                  state_d = ST_RUN;
`endif
               end else begin
                  state_d = ST_FETCH;
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
`ifdef LUT_LOAD_VERIFY_EN
         ST_VERIFY: begin
            // Read data lags the address by one cycle, so one drain cycle
            // collects the last byte before the sums are compared.
            if (!drain_q) begin
               if (&cnt_q) drain_d = 1'b1;
               else        cnt_d   = cnt_q + 1'b1;
            end else begin
               state_d = ST_RUN;
               if ((rsum_q + SUM_W'(LUT_RDATA)) != wsum_q) err_d = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge.
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef LUT_LOAD_VERIFY_EN
   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         wsum_q     <= '0;
         rsum_q     <= '0;
         drain_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wsum_q     <= wsum_d;
         rsum_q     <= rsum_d;
         drain_q    <= drain_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   assign ERR = err_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^LUT_RDATA;
   assign ERR          = 1'b0;
`endif

   // Output enable is only released in RUN (and VERIFY), where the strobe
   // generator is idle and LUT_N_WE is high.
   always_comb begin
      LUT_ADDR = addr_q;
      LUT_N_OE = 1'b1;
      if (state_q == ST_RUN) begin
         LUT_ADDR = RUN_ADDR;
         LUT_N_OE = ~RUN_RD;
      end
`ifdef LUT_LOAD_VERIFY_EN
      if ((state_q == ST_VERIFY) && !drain_q) begin
         LUT_ADDR = cnt_q;
         LUT_N_OE = 1'b0;
      end
`endif
   end

   assign LUT_WDATA = wdata_q;
   assign IN_READY  = (state_q == ST_FETCH);
   assign BUSY      = (state_q != ST_IDLE) && (state_q != ST_RUN);
   assign DONE      = (state_q == ST_RUN);

endmodule

// File: tb/tb_lut_load_ctrl.sv
// Self-checking bench for lut_load_ctrl: random streams against a write-log
// reference and a LUT model; the verify scenario applies when LUT_LOAD_VERIFY_EN is set.
`timescale 1ns/1ps
module tb_lut_load_ctrl;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int NB    = 1 << AW;
   localparam int SETUP = 1;
   localparam int PULSE = 2;
`ifdef LUT_LOAD_VERIFY_EN
   localparam int VERIFY_EDGES = NB + 1;
`else
   localparam int VERIFY_EDGES = 0;
`endif
   localparam int LOAD_EDGES = 1 + NB * (1 + SETUP + PULSE + 1) + VERIFY_EDGES;

   logic          CLK = 1'b0;
   logic          N_RST = 1'b1;
   logic          START = 1'b0;
   logic          IN_VALID = 1'b0;
   logic          IN_READY;
   logic [DW-1:0] IN_DATA = '0;
   logic [AW-1:0] RUN_ADDR = '0;
   logic          RUN_RD = 1'b0;
   logic [AW-1:0] LUT_ADDR;
   logic [DW-1:0] LUT_WDATA;
   logic          LUT_N_WE;
   logic          LUT_N_OE;
   logic [DW-1:0] LUT_RDATA = '0;
   logic          BUSY;
   logic          DONE;
   logic          ERR;

   int n_pass  = 0;
   int n_total = 0;

   lut_load_ctrl #(
      .ADDR_W (AW), .DATA_W (DW), .SETUP_CYCLES (SETUP), .PULSE_CYCLES (PULSE)
   ) dut (
      .CLK       (CLK),
      .N_RST     (N_RST),
      .START     (START),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .RUN_ADDR  (RUN_ADDR),
      .RUN_RD    (RUN_RD),
      .LUT_ADDR  (LUT_ADDR),
      .LUT_WDATA (LUT_WDATA),
      .LUT_N_WE  (LUT_N_WE),
      .LUT_N_OE  (LUT_N_OE),
      .LUT_RDATA (LUT_RDATA),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   // LUT model: byte written when the strobe rises, registered read data.
   logic [DW-1:0] lut_mem [NB];
   bit            corrupt = 1'b0;

   always @(posedge CLK)
      if (LUT_N_OE === 1'b0)
         LUT_RDATA <= lut_mem[LUT_ADDR] ^ ((corrupt && LUT_ADDR == 12'h7FF) ? 8'h01 : 8'h00);

   typedef struct {
      int addr;
      int data;
      int len;
      bit stable;
   } wr_t;

   wr_t           wr_log[$];
   wr_t           cur;
   bit            in_pulse = 1'b0;
   logic [DW-1:0] exp_data [NB];

   // Per-cycle monitor: strobe/enable exclusion, enable idle outside RUN, pulse log.
   always @(negedge CLK) begin
      logic oe_allowed;
      n_total++;
      if (LUT_N_WE === 1'b0 && LUT_N_OE === 1'b0)
         $display("FAIL we_oe_overlap t=%0t n_we=%b n_oe=%b want one high", $time, LUT_N_WE, LUT_N_OE);
      else
         n_pass++;
`ifdef LUT_LOAD_VERIFY_EN
      oe_allowed = (DONE === 1'b1) || (BUSY === 1'b1 && IN_READY === 1'b0);
`else
      oe_allowed = (DONE === 1'b1);
`endif
      if (!oe_allowed) begin
         n_total++;
         if (LUT_N_OE !== 1'b1)
            $display("FAIL oe_outside_run t=%0t n_oe=%b want 1", $time, LUT_N_OE);
         else
            n_pass++;
      end
      if (LUT_N_WE === 1'b0) begin
         if (!in_pulse) begin
            in_pulse   = 1'b1;
            cur.addr   = int'(LUT_ADDR);
            cur.data   = int'(LUT_WDATA);
            cur.len    = 1;
            cur.stable = 1'b1;
         end else begin
            cur.len++;
            if (int'(LUT_ADDR) != cur.addr || int'(LUT_WDATA) != cur.data) cur.stable = 1'b0;
         end
      end else if (in_pulse) begin
         in_pulse = 1'b0;
         wr_log.push_back(cur);
         lut_mem[cur.addr[AW-1:0]] = cur.data[DW-1:0];
      end
   end

   task automatic check_writes(input int n, input string tag);
      int bad   = 0;
      int first = -1;
      n_total++;
      if (wr_log.size() != n)
         $display("FAIL %s_pulse_count got %0d want %0d", tag, wr_log.size(), n);
      else
         n_pass++;
      for (int i = 0; i < wr_log.size() && i < n; i++) begin
         if (wr_log[i].addr != i || wr_log[i].data != int'(exp_data[i]) ||
             wr_log[i].len != PULSE || !wr_log[i].stable) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_total++;
      if (bad != 0)
         $display("FAIL %s_pulses %0d bad, first #%0d got addr=%0d data=%0h len=%0d stable=%0d want addr=%0d data=%0h len=%0d stable=1",
                  tag, bad, first, wr_log[first].addr, wr_log[first].data, wr_log[first].len,
                  wr_log[first].stable, first, exp_data[first], PULSE);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      #1 N_RST = 1'b0;
      IN_VALID = 1'b1;
      RUN_RD   = 1'b1;
      @(negedge CLK);
      n_total++;
      if ({LUT_N_WE, LUT_N_OE, IN_READY, BUSY, DONE, ERR} !== 6'b110000 ||
          LUT_ADDR !== '0 || LUT_WDATA !== '0)
         $display("FAIL reset_state got we=%b oe=%b rdy=%b busy=%b done=%b err=%b addr=%h wd=%h want 1 1 0 0 0 0 0 0",
                  LUT_N_WE, LUT_N_OE, IN_READY, BUSY, DONE, ERR, LUT_ADDR, LUT_WDATA);
      else
         n_pass++;
      N_RST = 1'b1;
      repeat (3) @(negedge CLK);
      n_total++;
      if (IN_READY !== 1'b0 || BUSY !== 1'b0 || LUT_N_OE !== 1'b1)
         $display("FAIL idle_ignores_inputs got rdy=%b busy=%b n_oe=%b want 0 0 1", IN_READY, BUSY, LUT_N_OE);
      else
         n_pass++;
      IN_VALID = 1'b0;
      RUN_RD   = 1'b0;
   endtask

   // Drives one load from a START pulse. Returns the edge count at which DONE
   // was seen, -1 on timeout, -2 when aborted by reset during byte 100.
   task automatic run_load(input bit gap3, input bit start50, input bit rst100,
                           input int valid_pct, input bit exp_err, input string tag,
                           output int done_k);
      int  k        = 0;
      int  accepted = 0;
      int  gap_left = 7;
      bit  s50      = 1'b0;
      bit  v;
      done_k = -1;
      wr_log.delete();
      @(negedge CLK);
      START = 1'b1;
      while (k < 60000) begin
         @(negedge CLK);
         k++;
         START = 1'b0;
         if (k == 1) begin
            n_total++;
            if (BUSY !== 1'b1 || DONE !== 1'b0 || IN_READY !== 1'b1 || ERR !== 1'b0)
               $display("FAIL %s_start got busy=%b done=%b rdy=%b err=%b want 1 0 1 0", tag, BUSY, DONE, IN_READY, ERR);
            else
               n_pass++;
         end
         if (DONE === 1'b1) begin
            done_k = k;
            break;
         end
         RUN_ADDR = AW'($urandom);
         RUN_RD   = 1'($urandom);
         if (rst100 && accepted == 101 && LUT_N_WE === 1'b0) begin
            N_RST = 1'b0;
            #1;
            n_total++;
            if (LUT_N_WE !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0 || IN_READY !== 1'b0)
               $display("FAIL %s_reset_mid_strobe got we=%b done=%b busy=%b rdy=%b want 1 0 0 0", tag, LUT_N_WE, DONE, BUSY, IN_READY);
            else
               n_pass++;
            IN_VALID = 1'b0;
            check_writes(100, tag);
            done_k = -2;
            return;
         end
         if (start50 && accepted == 50 && !s50) begin
            START = 1'b1;
            s50   = 1'b1;
         end
         v = ($urandom_range(99) < valid_pct);
         if (gap3 && accepted == 3 && gap_left > 0) begin
            v = 1'b0;
            if (IN_READY === 1'b1) begin
               n_total++;
               if (LUT_N_WE !== 1'b1 || LUT_ADDR !== 12'd2)
                  $display("FAIL %s_stall got n_we=%b addr=%0d want 1 2", tag, LUT_N_WE, LUT_ADDR);
               else
                  n_pass++;
               gap_left--;
            end
         end
         IN_VALID = v;
         IN_DATA  = (accepted < NB) ? exp_data[accepted] : DW'($urandom);
         if (v && IN_READY === 1'b1) accepted++;
      end
      n_total++;
      if (done_k < 0) begin
         $display("FAIL %s_timeout got no DONE after %0d cycles want DONE", tag, k);
         return;
      end else begin
         n_pass++;
      end
      // Bytes offered in RUN must not be taken.
      for (int i = 0; i < 4; i++) begin
         IN_VALID = 1'b1;
         IN_DATA  = DW'($urandom);
         @(negedge CLK);
      end
      IN_VALID = 1'b0;
      n_total++;
      if (accepted != NB || BUSY !== 1'b0 || IN_READY !== 1'b0 || DONE !== 1'b1 || ERR !== exp_err)
         $display("FAIL %s_end got acc=%0d busy=%b rdy=%b done=%b err=%b want %0d 0 0 1 %0d",
                  tag, accepted, BUSY, IN_READY, DONE, ERR, NB, exp_err);
      else
         n_pass++;
      check_writes(NB, tag);
   endtask

   task automatic test_full_load();
      int dk;
      for (int i = 0; i < NB; i++) exp_data[i] = DW'(i);
      run_load(1'b0, 1'b0, 1'b0, 100, 1'b0, "full", dk);
      n_total++;
      if (dk != LOAD_EDGES)
         $display("FAIL full_done_time got %0d want %0d", dk, LOAD_EDGES);
      else
         n_pass++;
   endtask

   task automatic test_run_read();
      logic [AW-1:0] a;
      logic          rd;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLK);
         a  = (i < 2) ? 12'h0A5 : AW'($urandom);
         rd = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom);
         RUN_ADDR = a;
         RUN_RD   = rd;
         #1;
         n_total++;
         if (LUT_ADDR !== a || LUT_N_OE !== ~rd || LUT_N_WE !== 1'b1 || DONE !== 1'b1)
            $display("FAIL run_read got addr=%h n_oe=%b n_we=%b done=%b want %h %b 1 1", LUT_ADDR, LUT_N_OE, LUT_N_WE, DONE, a, ~rd);
         else
            n_pass++;
      end
      RUN_RD = 1'b0;
   endtask

   task automatic test_back_to_back();
      int dk;
      for (int i = 0; i < NB; i++) exp_data[i] = DW'($urandom);
      run_load(1'b1, 1'b1, 1'b0, 90, 1'b0, "reload", dk);
   endtask

   task automatic test_reset_mid_load();
      int dk;
      for (int i = 0; i < NB; i++) exp_data[i] = DW'($urandom);
      run_load(1'b0, 1'b0, 1'b1, 90, 1'b0, "abort", dk);
      n_total++;
      if (dk != -2)
         $display("FAIL abort_reached got %0d want -2", dk);
      else
         n_pass++;
      @(negedge CLK);
      N_RST = 1'b1;
      @(negedge CLK);
      n_total++;
      if (DONE !== 1'b0 || BUSY !== 1'b0)
         $display("FAIL after_abort got done=%b busy=%b want 0 0", DONE, BUSY);
      else
         n_pass++;
      for (int i = 0; i < NB; i++) exp_data[i] = DW'($urandom);
`ifdef LUT_LOAD_VERIFY_EN
      corrupt = 1'b1;
      run_load(1'b0, 1'b0, 1'b0, 85, 1'b1, "postrst", dk);
`else
      run_load(1'b0, 1'b0, 1'b0, 85, 1'b0, "postrst", dk);
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_load();
      test_run_read();
      test_back_to_back();
      test_reset_mid_load();
      repeat (2) @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
